tf_rom_ctrl: RTL

- Sequencer for the twiddle-factor ROM in the radix-2, 2-BFU NTT core.
- LOAD mode: streams the packed twiddle table into the ROM through its write port.
- RUN mode: issues one ROM read per cycle, stage by stage, and presents each packed word (one twiddle per BFU) to the BFU pair on a valid/ready handshake, with a programmable bubble between stages.

---
 rtl/tf_pkg.sv | 34 +++
 rtl/tf_addr_gen.sv | 72 +++++++
 rtl/tf_rom_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/tf_pkg.sv
// -----------------------------------------------------------------------------
// tf_pkg
// Shared types and sizing helpers for the twiddle-factor ROM sequencer.
//   tf_state_e        : controller states (IDLE/LOAD/RUN/GAP/FIN)
//   STAGE_W           : width of the stage counter and the tf_stage port
//   LOGN_DEF, W, T    : default NTT size and the matching words-per-stage
//                       and table size
//   words_per_stage() : W = 2^(logn-2) (two twiddles packed per word)
//   table_size()      : T = logn * W
// -----------------------------------------------------------------------------
package tf_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    GAP  = 3'd3,
    FIN  = 3'd4
  } tf_state_e;

  localparam int STAGE_W  = 4;
  localparam int LOGN_DEF = 8;
  localparam int W        = 1 << (LOGN_DEF - 2);
  localparam int T        = LOGN_DEF * W;

  function automatic int words_per_stage(input int logn);
    return 1 << (logn - 2);
  endfunction

  function automatic int table_size(input int logn);
    return logn * words_per_stage(logn);
  endfunction

endpackage

// File: rtl/tf_addr_gen.sv
// -----------------------------------------------------------------------------
// tf_addr_gen
// Stage / index counters for RUN-mode ROM reads.
// The read address is stage*W + idx; W is a power of two, so the base is the
// physical stage shifted left by LOGN-2 with idx filling the low bits.
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   clr          : zero stage and idx (start of a RUN)
//   inc          : a read was issued this cycle, advance idx
//   stage_inc    : move to the next stage, idx back to 0
//   inv          : visit stages in reverse physical order
//   more         : idx < W, the current stage still has words to read
//   last_idx     : idx == W-1, the word being issued closes its stage
//   final_stage  : logical stage == LOGN-1
//   phys_stage   : physical stage of the current read
//   rd_addr      : ROM address of the current read
// -----------------------------------------------------------------------------
module tf_addr_gen
  import tf_pkg::*;
#(
  parameter int LOGN   = LOGN_DEF,
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  input  logic               stage_inc,
  input  logic               inv,
  output logic               more,
  output logic               last_idx,
  output logic               final_stage,
  output logic [STAGE_W-1:0] phys_stage,
  output logic [ADDR_W-1:0]  rd_addr
);

  // idx must be able to hold W itself (the "stage exhausted" value)
  localparam int IDX_W = LOGN - 1;
  localparam int SH    = LOGN - 2;

  localparam logic [IDX_W-1:0]   IDX_END    = IDX_W'(words_per_stage(LOGN));
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(words_per_stage(LOGN) - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOGN - 1);

  logic [IDX_W-1:0]   idx_q;
  logic [STAGE_W-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q   <= '0;
      stage_q <= '0;
    end else if (clr) begin
      idx_q   <= '0;
      stage_q <= '0;
    end else if (stage_inc) begin
      idx_q   <= '0;
      stage_q <= stage_q + 1'b1;
    end else if (inc) begin
      idx_q   <= idx_q + 1'b1;
    end
  end

  assign more        = (idx_q < IDX_END);
  assign last_idx    = (idx_q == IDX_LAST);
  assign final_stage = (stage_q == STAGE_LAST);
  assign phys_stage  = inv ? (STAGE_LAST - stage_q) : stage_q;

  // low idx bits only; idx never reaches W while a read is issued
  assign rd_addr = (ADDR_W'(phys_stage) << SH) | ADDR_W'(idx_q[SH-1:0]);

endmodule

// File: rtl/tf_rom_ctrl.sv
// -----------------------------------------------------------------------------
// tf_rom_ctrl
// Twiddle-factor ROM sequencer for the radix-2, 2-BFU NTT core.
//   LOAD: streams T packed words into the ROM write port.
//   RUN : reads the table stage by stage, one word per cycle, and hands each
//         word to the BFU pair over valid/ready, with STAGE_GAP idle cycles
//         between stages.
// Optional build macro TF_ROM_CTRL_INTT_EN adds the 'inv' input (sampled with
// start) that walks the stages in reverse physical order.
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   ld_start              : IDLE pulse -> LOAD (wins over start)
//   ld_valid/ld_data      : load word stream; ld_ready high during LOAD
//   start                 : IDLE pulse -> RUN
//   inv                   : (TF_ROM_CTRL_INTT_EN only) reverse stage order
//   busy                  : controller not idle
//   done                  : one-cycle pulse at the end of LOAD or RUN
//   tf_valid/tf_ready     : word handshake towards the BFU pair
//   tf_data               : ROM read data, passed straight through
//   tf_stage, tf_last     : physical stage of tf_data, last word of stage
//   rom_en, rom_ren       : ROM enable; ren=0 write, ren=1 read
//   rom_a, rom_d, rom_q   : ROM address, write data, registered read data
//
// state | meaning
// IDLE  | waiting for ld_start / start
// LOAD  | writing table words as ld_valid arrives
// RUN   | issuing reads of the current stage, draining the handshake
// GAP   | STAGE_GAP idle cycles before the next stage
// FIN   | done pulse, back to IDLE
// -----------------------------------------------------------------------------
module tf_rom_ctrl
  import tf_pkg::*;
#(
  parameter int LOGN      = LOGN_DEF,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 28,
  parameter int STAGE_GAP = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_start,
  input  logic               ld_valid,
  input  logic [DATA_W-1:0]  ld_data,
  output logic               ld_ready,
  input  logic               start,
`ifdef TF_ROM_CTRL_INTT_EN
  input  logic               inv,
`endif
  output logic               busy,
  output logic               done,
  output logic               tf_valid,
  input  logic               tf_ready,
  output logic [DATA_W-1:0]  tf_data,
  output logic [STAGE_W-1:0] tf_stage,
  output logic               tf_last,
  output logic               rom_en,
  output logic               rom_ren,
  output logic [ADDR_W-1:0]  rom_a,
  output logic [DATA_W-1:0]  rom_d,
  input  logic [DATA_W-1:0]  rom_q
);

  localparam int TSZ = table_size(LOGN);
  localparam logic [ADDR_W-1:0] LAST_WADDR = ADDR_W'(TSZ - 1);

  localparam int GAP_CW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam logic [GAP_CW-1:0] GAP_LOAD =
      GAP_CW'((STAGE_GAP > 0) ? (STAGE_GAP - 1) : 0);

  tf_state_e state_q, state_d;

  logic               issue, wr, run_clr, stage_inc, gap_load, accept;
  logic               ag_more, ag_last, ag_final, inv_eff;
  logic [STAGE_W-1:0] ag_stage;
  logic [ADDR_W-1:0]  ag_addr;

  logic [ADDR_W-1:0]  wcnt_q;
  logic [GAP_CW-1:0]  gcnt_q;
  logic               valid_q, last_q, done_q, busy_q, ldr_q;
  logic [STAGE_W-1:0] stage_q;

  tf_addr_gen #(
    .LOGN   (LOGN),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (run_clr),
    .inc         (issue),
    .stage_inc   (stage_inc),
    .inv         (inv_eff),
    .more        (ag_more),
    .last_idx    (ag_last),
    .final_stage (ag_final),
    .phys_stage  (ag_stage),
    .rd_addr     (ag_addr)
  );

`ifdef TF_ROM_CTRL_INTT_EN
  logic inv_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inv_q <= 1'b0;
    end else if (state_q == IDLE && start && !ld_start) begin
      inv_q <= inv;
    end
  end

  assign inv_eff = inv_q;
`else
  assign inv_eff = 1'b0;
`endif

  assign accept = valid_q && tf_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    wr        = 1'b0;
    run_clr   = 1'b0;
    stage_inc = 1'b0;
    gap_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d = LOAD;
        end else if (start) begin
          state_d = RUN;
          run_clr = 1'b1;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          wr = 1'b1;
          if (wcnt_q == LAST_WADDR) state_d = FIN;
        end
      end
      RUN: begin
        // a read may go out whenever the output slot is free or being freed
        issue = ag_more && (!valid_q || tf_ready);
        if (accept && last_q) begin
          if (ag_final) begin
            state_d = FIN;
          end else if (STAGE_GAP == 0) begin
            stage_inc = 1'b1;
          end else begin
            state_d  = GAP;
            gap_load = 1'b1;
          end
        end
      end
      GAP: begin
        if (gcnt_q == '0) begin
          state_d   = RUN;
          stage_inc = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt_q  <= '0;
      gcnt_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      stage_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ldr_q   <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == FIN);
      ldr_q  <= (state_d == LOAD);

      if (state_q == IDLE && ld_start) begin
        wcnt_q <= '0;
      end else if (wr) begin
        wcnt_q <= wcnt_q + 1'b1;
      end

      if (gap_load) begin
        gcnt_q <= GAP_LOAD;
      end else if (state_q == GAP && gcnt_q != '0) begin
        gcnt_q <= gcnt_q - 1'b1;
      end

      // word on tf_data next cycle belongs to the read issued now
      if (issue) begin
        valid_q <= 1'b1;
        last_q  <= ag_last;
        stage_q <= ag_stage;
      end else if (accept) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign ld_ready = ldr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tf_valid = valid_q;
  assign tf_last  = last_q;
  assign tf_stage = stage_q;
  assign tf_data  = rom_q;

  assign rom_en  = wr || issue;
  assign rom_ren = issue;
  assign rom_a   = wr ? wcnt_q : ag_addr;
  assign rom_d   = ld_data;

endmodule
